// File: rtl/noc_pkg.sv
// Shared mesh-router constants: port codes, flit types, code decode.
// Used by the switch allocator and its per-output arbiters.
package noc_pkg;

  localparam logic [2:0] LOCAL = 3'b001;
  localparam logic [2:0] EAST  = 3'b010;
  localparam logic [2:0] WEST  = 3'b011;
  localparam logic [2:0] NORTH = 3'b100;
  localparam logic [2:0] SOUTH = 3'b101;

  localparam logic [1:0] HDR  = 2'b11;
  localparam logic [1:0] BODY = 2'b10;
  localparam logic [1:0] TAIL = 2'b01;

  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
  } port_map_t;

  function automatic port_map_t code2idx(input logic [2:0] op);
    port_map_t m;
    m.ok  = 1'b1;
    m.idx = 3'd0;
    case (op)
      LOCAL:   m.idx = 3'd0;
      EAST:    m.idx = 3'd1;
      WEST:    m.idx = 3'd2;
      NORTH:   m.idx = 3'd3;
      SOUTH:   m.idx = 3'd4;
      default: m.ok  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: first request at or after ptr, wrapping.
// One-hot grant, all zeros when nothing requests.
module rr_arb #(
  parameter int NP = 5
) (
  input  logic [NP-1:0] req,
  input  logic [2:0]    ptr,
  output logic [NP-1:0] gnt
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NP; k++) begin
      j = (int'(ptr) + k) % NP;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_alloc_rr.sv
// Wormhole switch allocator: per-output lock tables, round-robin
// header arbitration, protocol error flag and crossbar select.
module sw_alloc_rr
  import noc_pkg::*;
#(
  parameter int NP = 5,
  parameter int FW = 39,
  localparam int TW = FW - (FW - 1) + 1
) (
  input  logic             clk_t,
  input  logic             rst_t,
  input  logic [NP-1:0]    req_valid,
  input  logic [TW*NP-1:0] req_type,
  input  logic [3*NP-1:0]  req_op,
  input  logic [NP-1:0]    out_ready,
  output logic [NP-1:0]    grant,
  output logic [NP-1:0]    xbar_vld,
  output logic [3*NP-1:0]  xbar_sel,
  output logic             err
);

  logic [NP-1:0] out_lock;
  logic [2:0]    out_own [NP];
  logic [2:0]    rr      [NP];
  logic [NP-1:0] in_lock;
  logic [2:0]    in_out  [NP];
  logic          err_q;

  logic [TW-1:0] typ [NP];
  port_map_t     pm  [NP];
  logic [NP-1:0] is_hdr;
  logic [NP-1:0] is_bt;
  logic [NP-1:0] is_tail;
  logic [NP-1:0] hdr_ok;
  logic [NP-1:0] bt_go;
  logic [NP-1:0] bad;
  logic [NP-1:0] hwin;

  logic [NP-1:0] creq [NP];
  logic [NP-1:0] wgnt [NP];
  logic [2:0]    widx [NP];

  logic [NP-1:0]   grant_c;
  logic [NP-1:0]   vld_c;
  logic [3*NP-1:0] sel_c;

  function automatic logic [2:0] oh2idx(input logic [NP-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NP; i++)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

  always_comb begin
    is_hdr  = '0;
    is_bt   = '0;
    is_tail = '0;
    hdr_ok  = '0;
    bt_go   = '0;
    bad     = '0;
    for (int i = 0; i < NP; i++) begin
      typ[i]     = req_type[TW*i +: TW];
      pm[i]      = code2idx(req_op[3*i +: 3]);
      is_hdr[i]  = req_valid[i] && typ[i] == HDR;
      is_bt[i]   = req_valid[i] &&
                   (typ[i] == BODY || typ[i] == TAIL);
      is_tail[i] = typ[i] == TAIL;
      hdr_ok[i]  = is_hdr[i] && pm[i].ok && !in_lock[i];
      bt_go[i]   = is_bt[i] && in_lock[i] &&
                   out_ready[in_out[i]];
      bad[i]     = (is_hdr[i] && (!pm[i].ok || in_lock[i])) ||
                   (is_bt[i] && !in_lock[i]) ||
                   (req_valid[i] && typ[i] == 2'b00);
    end
  end

  // Headers only compete for free outputs that can take a flit now.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      creq[o] = '0;
      for (int i = 0; i < NP; i++)
        creq[o][i] = hdr_ok[i] && pm[i].idx == 3'(o) &&
                     !out_lock[o] && out_ready[o];
    end
  end

  for (genvar g = 0; g < NP; g++) begin : g_arb
    rr_arb #(.NP(NP)) u_arb (
      .req (creq[g]),
      .ptr (rr[g]),
      .gnt (wgnt[g])
    );
  end

  always_comb begin
    hwin = '0;
    for (int o = 0; o < NP; o++) begin
      widx[o] = oh2idx(wgnt[o]);
      hwin    = hwin | wgnt[o];
    end
  end

  always_comb begin
    grant_c = hwin | bt_go;
    vld_c   = '0;
    sel_c   = '0;
    for (int o = 0; o < NP; o++) begin
      if (out_lock[o]) begin
        vld_c[o] = bt_go[out_own[o]];
        if (vld_c[o]) sel_c[3*o +: 3] = out_own[o];
      end else begin
        vld_c[o] = |wgnt[o];
        if (vld_c[o]) sel_c[3*o +: 3] = widx[o];
      end
    end
  end

  assign grant    = rst_t ? '0 : grant_c;
  assign xbar_vld = rst_t ? '0 : vld_c;
  assign xbar_sel = rst_t ? '0 : sel_c;
  assign err      = err_q;

  always_ff @(posedge clk_t) begin
    if (rst_t) begin
      out_lock <= '0;
      in_lock  <= '0;
      err_q    <= 1'b0;
      for (int o = 0; o < NP; o++) begin
        out_own[o] <= '0;
        rr[o]      <= '0;
        in_out[o]  <= '0;
      end
    end else begin
      err_q <= err_q | (|bad);
      for (int o = 0; o < NP; o++) begin
        if (out_lock[o]) begin
          if (bt_go[out_own[o]] && is_tail[out_own[o]])
            out_lock[o] <= 1'b0;
        end else if (|wgnt[o]) begin
          out_lock[o] <= 1'b1;
          out_own[o]  <= widx[o];
          rr[o]       <= (widx[o] == 3'(NP - 1)) ?
                         3'd0 : widx[o] + 3'd1;
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (bt_go[i] && is_tail[i]) begin
          in_lock[i] <= 1'b0;
        end else if (hwin[i]) begin
          in_lock[i] <= 1'b1;
          in_out[i]  <= pm[i].idx;
        end
      end
    end
  end

endmodule
